// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and RAM-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    // fetch port
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;
    // data port
    logic                  d_req;
    logic [31:0]           d_addr;
    logic [DATA_W/8-1:0]   d_wmask;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    // single-port RAM
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W/8-1:0]   m_wea;
    logic [DATA_W-1:0]     m_din;
    logic [DATA_W-1:0]     m_dout;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, m_dout,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wea, m_din
    );

    // requester / RAM environment side
    modport master (
        output i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, m_dout,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wea, m_din
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 1-cycle-latency RAM between fetch and data ports (ARB_STARVE_GUARD_EN adds fetch anti-starvation)
module mem_port_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    mem_port_arbiter_if.slave bus_io
);

    // Owner of the read launched in the previous cycle; NONE after writes and idle cycles.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e owner_q;
    owner_e owner_d;
    logic   grant_i;
    logic   grant_d;
    logic   fetch_forced;
    logic   unused_ok;

`ifdef ARB_STARVE_GUARD_EN
    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    assign fetch_forced = bus_io.i_req && (starve_cnt_q == CNT_MAX);

    // Count consecutive cycles a pending fetch loses; saturate, clear on grant or idle.
    always_comb begin
        starve_cnt_d = '0;
        if (bus_io.i_req && !grant_i) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign unused_ok = ^{bus_io.i_addr[31:ADDR_W+2], bus_io.i_addr[1:0],
                         bus_io.d_addr[31:ADDR_W+2], bus_io.d_addr[1:0]};
`else
    assign fetch_forced = 1'b0;

    assign unused_ok = ^{bus_io.i_addr[31:ADDR_W+2], bus_io.i_addr[1:0],
                         bus_io.d_addr[31:ADDR_W+2], bus_io.d_addr[1:0],
                         (STARVE_LIMIT != 0)};
`endif

    // Pick at most one requester; data wins unless fetch has been starved. Nothing is granted in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n_i) begin
            if (fetch_forced) begin
                grant_i = 1'b1;
            end else if (bus_io.d_req) begin
                grant_d = 1'b1;
            end else if (bus_io.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // Next owner: only a granted read produces a return in the following cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (grant_i) begin
            owner_d = OWN_I;
        end else if (grant_d && (bus_io.d_wmask == '0)) begin
            owner_d = OWN_D;
        end
    end

    // Owner register; reset drops any read in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // RAM drive and return steering; read data is a straight path from the RAM output.
    always_comb begin
        bus_io.i_gnt    = grant_i;
        bus_io.d_gnt    = grant_d;
        bus_io.m_addr   = grant_d ? bus_io.d_addr[ADDR_W+1:2] : bus_io.i_addr[ADDR_W+1:2];
        bus_io.m_wea    = grant_d ? bus_io.d_wmask : '0;
        bus_io.m_din    = bus_io.d_wdata;
        bus_io.i_rvalid = (owner_q == OWN_I);
        bus_io.d_rvalid = (owner_q == OWN_D);
        bus_io.i_rdata  = bus_io.m_dout;
        bus_io.d_rdata  = bus_io.m_dout;
    end

endmodule
